// File: rtl/word_frame_tx_module_pkg.sv
// Shared definitions for the word framer: defaults, frame length and FSM encoding.
// Frame on the wire is HEADER, data bytes MSB first, then an 8-bit additive checksum.
package word_frame_tx_module_pkg;

    localparam int         WORD_BYTES_DEF  = 3;
    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

    // Header + data bytes + checksum.
    function automatic int frame_len(input int word_bytes);
        return word_bytes + 2;
    endfunction

endpackage

// File: rtl/word_frame_tx_module_if.sv
// Request side (word in, send request) and TX FIFO write side of the word framer.
// The framer is the slave; the block feeding it words and watching the FIFO is the master.
interface word_frame_tx_module_if #(
    parameter int WORD_BYTES = 3
);
    logic                    Send_Req_Sig;
    logic [8*WORD_BYTES-1:0] Word_In;
    logic                    Full_Sig;
    logic                    Write_Req_Sig;
    logic [7:0]              FIFO_Write_Data;
    logic                    Busy_Sig;
    logic                    Done_Sig;
    logic                    Drop_Sig;

    modport master (
        output Send_Req_Sig, Word_In, Full_Sig,
        input  Write_Req_Sig, FIFO_Write_Data, Busy_Sig, Done_Sig, Drop_Sig
    );

    modport slave (
        input  Send_Req_Sig, Word_In, Full_Sig,
        output Write_Req_Sig, FIFO_Write_Data, Busy_Sig, Done_Sig, Drop_Sig
    );
endinterface

// File: rtl/word_frame_tx_module.sv
// Packs a captured word into [HEADER, MSB..LSB, CHECKSUM] and writes it to the TX FIFO,
// one byte every other cycle so Full_Sig has a cycle to reflect each write.
module word_frame_tx_module
    import word_frame_tx_module_pkg::*;
#(
    parameter int         WORD_BYTES  = WORD_BYTES_DEF,
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    word_frame_tx_module_if.slave       bus
);

    localparam int          FRAME_LEN = frame_len(WORD_BYTES);
    localparam int          IW        = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    tx_state_e               state_q, state_n;
    logic [IW-1:0]           idx_q, idx_n;
    logic [8*WORD_BYTES-1:0] shadow_q, shadow_n;
    logic [7:0]              csum_q, csum_n;
    logic [7:0]              data_q, data_n;
    logic                    wr_q, wr_n;
    logic                    done_q, done_n;
    logic                    drop_q, drop_n;
    logic                    busy_q, busy_n;
    logic [7:0]              sum_in;
    logic [7:0]              byte_cur;

    always_comb begin
        sum_in = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            sum_in = sum_in + bus.Word_In[8*i +: 8];
    end

    // Index 0 is the header, 1..WORD_BYTES walk the shadow word MSB first, last is checksum.
    always_comb begin
        byte_cur = csum_q;
        if (idx_q == '0)
            byte_cur = HEADER_BYTE;
        else
            for (int i = 1; i <= WORD_BYTES; i++)
                if (idx_q == IW'(i))
                    byte_cur = shadow_q[8*(WORD_BYTES-i) +: 8];
    end

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        shadow_n = shadow_q;
        csum_n   = csum_q;
        data_n   = data_q;
        wr_n     = 1'b0;
        done_n   = 1'b0;
        drop_n   = bus.Send_Req_Sig && (state_q != IDLE);
        unique case (state_q)
            IDLE: if (bus.Send_Req_Sig) begin
                shadow_n = bus.Word_In;
                csum_n   = sum_in;
                idx_n    = '0;
                state_n  = WRITE;
            end
            WRITE: if (!bus.Full_Sig) begin
                wr_n    = 1'b1;
                data_n  = byte_cur;
                state_n = GAP;
            end
            GAP: if (idx_q == LAST_IDX) begin
                done_n  = 1'b1;
                state_n = DONE;
            end else begin
                idx_n   = idx_q + 1'b1;
                state_n = WRITE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            csum_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            shadow_q <= shadow_n;
            csum_q   <= csum_n;
            data_q   <= data_n;
            wr_q     <= wr_n;
            done_q   <= done_n;
            drop_q   <= drop_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.Write_Req_Sig   = wr_q;
    assign bus.FIFO_Write_Data = data_q;
    assign bus.Busy_Sig        = busy_q;
    assign bus.Done_Sig        = done_q;
    assign bus.Drop_Sig        = drop_q;

endmodule
